// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory arbiter: FSM states, grant
// encoding, device select values and the round-robin grant decision.
`timescale 1ns/1ps
package spi_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE
  } arb_state_t;

  // Which master owns the current (or most recent) transaction.
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam logic DEV_SRAM     = 1'b0;
  localparam logic DEV_EEPROM   = 1'b1;
  localparam int   DEV_ADDR_BIT = 16;
  localparam int   MEM_AW       = 14;

  // Single requester wins outright; on a tie the master that did not win
  // last time is served.
  function automatic grant_t pick_grant(input logic   i_cyc,
                                        input logic   d_cyc,
                                        input grant_t last);
    grant_t g;
    if (i_cyc && d_cyc) begin
      if (last == GNT_I) g = GNT_D;
      else               g = GNT_I;
    end else if (d_cyc) begin
      g = GNT_D;
    end else begin
      g = GNT_I;
    end
    return g;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Bus bundle between the SERV instruction/data buses, the arbiter and the
// SPI memory controller. The arbiter uses the slave view; the surrounding
// environment (core side and controller side) uses the master view.
`timescale 1ns/1ps
interface spi_mem_arbiter_if;

  // SERV instruction bus (read only)
  logic        ibus_cyc;
  logic [31:0] ibus_adr;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;

  // SERV data bus
  logic        dbus_cyc;
  logic        dbus_we;
  logic [31:0] dbus_adr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_dat;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;

  // SPI memory controller Wishbone port
  logic        mem_cyc;
  logic [13:0] mem_adr;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_dat_w;
  logic [31:0] mem_dat_r;
  logic        mem_ack;

  // Device steering and sticky error
  logic        dev_sel;
  logic        err;

  modport slave (
    input  ibus_cyc, ibus_adr,
    output ibus_rdt, ibus_ack,
    input  dbus_cyc, dbus_we, dbus_adr, dbus_sel, dbus_dat,
    output dbus_rdt, dbus_ack,
    output mem_cyc, mem_adr, mem_we, mem_sel, mem_dat_w,
    input  mem_dat_r, mem_ack,
    output dev_sel, err
  );

  modport master (
    output ibus_cyc, ibus_adr,
    input  ibus_rdt, ibus_ack,
    output dbus_cyc, dbus_we, dbus_adr, dbus_sel, dbus_dat,
    input  dbus_rdt, dbus_ack,
    input  mem_cyc, mem_adr, mem_we, mem_sel, mem_dat_w,
    output mem_dat_r, mem_ack,
    input  dev_sel, err
  );

endinterface

// File: rtl/spi_mem_arbiter.sv
// Shares the SPI memory controller's single Wishbone port between the SERV
// instruction and data buses. Round-robin on ties, decodes SRAM vs EEPROM
// from address bit 16, rejects EEPROM writes with a sticky error, and always
// leaves the controller one cyc-low cycle (S_RELEASE) plus one idle cycle
// before the next request.
`timescale 1ns/1ps
module spi_mem_arbiter
  import spi_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  spi_mem_arbiter_if.slave  bus
);

  arb_state_t          r_state;
  grant_t              r_grant;
  grant_t              r_last_grant;
  logic                r_mem_cyc;
  logic [MEM_AW-1:0]   r_mem_adr;
  logic                r_mem_we;
  logic [3:0]          r_mem_sel;
  logic [31:0]         r_mem_dat_w;
  logic                r_dev_sel;
  logic                r_err;
  logic [31:0]         r_rdt;
  logic                r_ibus_ack;
  logic                r_dbus_ack;

  // Request selection for the S_IDLE decision.
  grant_t              w_grant;
  logic                w_any_req;
  logic                w_gnt_d;
  logic [31:0]         w_adr;
  logic                w_we;
  logic                w_reject;
  logic                w_reject_pending;
  logic                w_unused;

  assign w_any_req = bus.ibus_cyc | bus.dbus_cyc;
  assign w_grant   = pick_grant(bus.ibus_cyc, bus.dbus_cyc, r_last_grant);
  assign w_gnt_d   = (w_grant == GNT_D);
  assign w_adr     = w_gnt_d ? bus.dbus_adr : bus.ibus_adr;
  assign w_we      = w_gnt_d & bus.dbus_we;
  assign w_reject  = w_we & (w_adr[DEV_ADDR_BIT] == DEV_EEPROM);

  // Only data-bus writes latch mem_we, so this marks a latched EEPROM write.
  assign w_reject_pending = r_mem_we & (r_dev_sel == DEV_EEPROM);

  // Address bits outside [16:2] carry no meaning for this memory map.
  assign w_unused = ^{bus.ibus_adr[31:DEV_ADDR_BIT+1], bus.ibus_adr[1:0],
                      bus.dbus_adr[31:DEV_ADDR_BIT+1], bus.dbus_adr[1:0]};

  // Arbitration FSM with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= GNT_I;
      r_last_grant <= GNT_D;
      r_mem_cyc    <= 1'b0;
      r_mem_adr    <= '0;
      r_mem_we     <= 1'b0;
      r_mem_sel    <= '0;
      r_mem_dat_w  <= '0;
      r_dev_sel    <= DEV_SRAM;
      r_err        <= 1'b0;
      r_rdt        <= '0;
      r_ibus_ack   <= 1'b0;
      r_dbus_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            r_mem_adr    <= w_adr[DEV_ADDR_BIT-1:2];
            r_dev_sel    <= w_adr[DEV_ADDR_BIT];
            r_mem_we     <= w_we;
            r_mem_sel    <= w_gnt_d ? bus.dbus_sel : 4'b1111;
            r_mem_dat_w  <= w_gnt_d ? bus.dbus_dat : 32'h0;
            // An EEPROM write never reaches the controller.
            r_mem_cyc    <= ~w_reject;
            r_state      <= S_REQ;
          end
        end

        S_REQ: begin
          // A rejected write spends this one cycle here with cyc low, so its
          // ack lands two cycles after sampling like a zero-latency access.
          if (w_reject_pending) begin
            r_err      <= 1'b1;
            r_rdt      <= '0;
            r_ibus_ack <= (r_grant == GNT_I);
            r_dbus_ack <= (r_grant == GNT_D);
            r_state    <= S_RELEASE;
          end else if (bus.mem_ack) begin
            r_mem_cyc  <= 1'b0;
            r_rdt      <= r_mem_we ? 32'h0 : bus.mem_dat_r;
            r_ibus_ack <= (r_grant == GNT_I);
            r_dbus_ack <= (r_grant == GNT_D);
            r_state    <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          // Controller sees cyc low here; no request is sampled.
          r_ibus_ack <= 1'b0;
          r_dbus_ack <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_cyc   = r_mem_cyc;
  assign bus.mem_adr   = r_mem_adr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_sel   = r_mem_sel;
  assign bus.mem_dat_w = r_mem_dat_w;
  assign bus.dev_sel   = r_dev_sel;
  assign bus.err       = r_err;
  assign bus.ibus_rdt  = r_rdt;
  assign bus.dbus_rdt  = r_rdt;
  assign bus.ibus_ack  = r_ibus_ack;
  assign bus.dbus_ack  = r_dbus_ack;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: models the SPI controller with a programmable
// latency and two device memories, drives the two SERV buses, and compares
// against a transaction-level reference (memory arrays, grant order, err).
`timescale 1ns/1ps
module tb_spi_mem_arbiter;
  import spi_mem_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_arbiter_if bus ();

  spi_mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Device contents seen by the controller model, and the reference copy
  // updated only from what the masters asked for.
  logic [31:0] dev_mem [2][16384];
  logic [31:0] ref_mem [2][16384];
  bit          model_err = 1'b0;

  typedef struct packed {
    logic [13:0] adr;
    logic        dev;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } mem_req_t;

  mem_req_t ctl_log[$];
  int       ctl_lat    = 0;
  int       ctl_cnt    = 0;
  bit       ctl_active = 1'b0;

  // Controller model: acks ctl_lat cycles after first seeing cyc, holds ack
  // while cyc stays high.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_ack = 1'b0;
      ctl_active  = 1'b0;
      ctl_cnt     = 0;
    end else if (bus.mem_cyc) begin
      if (!ctl_active) begin
        ctl_active = 1'b1;
        ctl_cnt    = ctl_lat;
        ctl_log.push_back('{bus.mem_adr, bus.dev_sel, bus.mem_we,
                            bus.mem_sel, bus.mem_dat_w});
      end
      if (!bus.mem_ack) begin
        if (ctl_cnt == 0) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
              if (bus.mem_sel[b])
                dev_mem[bus.dev_sel][bus.mem_adr][8*b +: 8] = bus.mem_dat_w[8*b +: 8];
            bus.mem_dat_r = $urandom;
          end else begin
            bus.mem_dat_r = dev_mem[bus.dev_sel][bus.mem_adr];
          end
        end else begin
          ctl_cnt--;
        end
      end
    end else begin
      bus.mem_ack = 1'b0;
      ctl_active  = 1'b0;
    end
  end

  // Ack / cyc monitor.
  int ack_i_pulses = 0, ack_d_pulses = 0, ack_long = 0, ack_overlap = 0;
  bit prev_i = 0, prev_d = 0, prev_cyc = 0, gap_seen = 0;
  int low_run = 0, min_gap = 1000;
  always @(negedge clk) begin
    if (bus.ibus_ack && !prev_i) ack_i_pulses++;
    if (bus.ibus_ack &&  prev_i) ack_long++;
    if (bus.dbus_ack && !prev_d) ack_d_pulses++;
    if (bus.dbus_ack &&  prev_d) ack_long++;
    if ((bus.ibus_ack || bus.dbus_ack) && bus.mem_cyc) ack_overlap++;
    if (bus.ibus_ack && bus.dbus_ack) ack_overlap++;
    if (bus.mem_cyc) begin
      if (!prev_cyc) begin
        if (gap_seen && low_run < min_gap) min_gap = low_run;
        gap_seen = 1'b1;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_i   = bus.ibus_ack;
    prev_d   = bus.dbus_ack;
    prev_cyc = bus.mem_cyc;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    model_err = 1'b0;
  endtask

  // One transaction from one master, checked for latency, data, request
  // fields seen by the controller, ack pulses and err.
  task automatic run_single(input bit is_d, input bit we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat,
                            input int lat, input string tag);
    int n, exp_lat, log0, pi0, pd0, lo0, ov0, exp_log;
    bit got, reject;
    logic [31:0] rdt, exp_rdt;
    mem_req_t e;
    reject  = is_d && we && adr[16];
    exp_rdt = (is_d && we) ? 32'h0 : ref_mem[adr[16]][adr[15:2]];
    exp_lat = reject ? 2 : lat + 2;
    log0 = ctl_log.size(); pi0 = ack_i_pulses; pd0 = ack_d_pulses;
    lo0 = ack_long; ov0 = ack_overlap;
    @(negedge clk);
    ctl_lat = lat;
    if (is_d) begin
      bus.dbus_we = we; bus.dbus_adr = adr; bus.dbus_sel = sel;
      bus.dbus_dat = dat; bus.dbus_cyc = 1'b1;
    end else begin
      bus.ibus_adr = adr; bus.ibus_cyc = 1'b1;
    end
    n = 0; got = 1'b0; rdt = 'x;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (is_d ? bus.dbus_ack : bus.ibus_ack) begin
        got = 1'b1;
        rdt = is_d ? bus.dbus_rdt : bus.ibus_rdt;
      end
    end
    bus.ibus_cyc = 1'b0;
    bus.dbus_cyc = 1'b0;
    if (reject) model_err = 1'b1;
    if (is_d && we && !reject)
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[adr[16]][adr[15:2]][8*b +: 8] = dat[8*b +: 8];
    repeat (2) @(negedge clk);

    n_vec++;
    if (!got) begin
      n_miss++;
      $display("FAIL %s ack_timeout: waited %0d cycles, expected ack after %0d", tag, n, exp_lat);
    end else if (n !== exp_lat) begin
      n_miss++;
      $display("FAIL %s latency: got %0d expected %0d", tag, n, exp_lat);
    end
    n_vec++;
    if (rdt !== exp_rdt) begin
      n_miss++;
      $display("FAIL %s rdt: got %08h expected %08h", tag, rdt, exp_rdt);
    end
    exp_log = log0 + (reject ? 0 : 1);
    n_vec++;
    if (ctl_log.size() !== exp_log) begin
      n_miss++;
      $display("FAIL %s mem_requests: got %0d expected %0d", tag, ctl_log.size(), exp_log);
    end else if (!reject) begin
      e = ctl_log[log0];
      n_vec++;
      if ({e.adr, e.dev, e.we, e.sel} !== {adr[15:2], adr[16], is_d && we, is_d ? sel : 4'hF}) begin
        n_miss++;
        $display("FAIL %s mem_req: got adr=%h dev=%b we=%b sel=%b expected adr=%h dev=%b we=%b sel=%b",
                 tag, e.adr, e.dev, e.we, e.sel, adr[15:2], adr[16], is_d && we, is_d ? sel : 4'hF);
      end
      if (is_d && we) begin
        n_vec++;
        if (e.dat !== dat) begin
          n_miss++;
          $display("FAIL %s mem_dat_w: got %08h expected %08h", tag, e.dat, dat);
        end
      end
    end
    n_vec++;
    if ({ack_i_pulses - pi0, ack_d_pulses - pd0, ack_long - lo0, ack_overlap - ov0} !==
        {(is_d ? 32'd0 : 32'd1), (is_d ? 32'd1 : 32'd0), 32'd0, 32'd0}) begin
      n_miss++;
      $display("FAIL %s ack_pulses: got i=%0d d=%0d long=%0d overlap=%0d expected i=%0d d=%0d long=0 overlap=0",
               tag, ack_i_pulses - pi0, ack_d_pulses - pd0, ack_long - lo0, ack_overlap - ov0,
               is_d ? 0 : 1, is_d ? 1 : 0);
    end
    n_vec++;
    if (bus.err !== model_err) begin
      n_miss++;
      $display("FAIL %s err: got %b expected %b", tag, bus.err, model_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.ibus_ack, bus.dbus_ack, bus.mem_cyc, bus.mem_we, bus.dev_sel, bus.err} !== 6'b0) begin
      n_miss++;
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.ibus_ack, bus.dbus_ack, bus.mem_cyc, bus.mem_we, bus.dev_sel, bus.err});
    end
    n_vec++;
    if ({bus.mem_adr, bus.mem_sel, bus.mem_dat_w} !== 50'h0) begin
      n_miss++;
      $display("FAIL reset_mem_regs: got adr=%h sel=%h dat=%h expected 0",
               bus.mem_adr, bus.mem_sel, bus.mem_dat_w);
    end
    n_vec++;
    if ({bus.ibus_rdt, bus.dbus_rdt} !== 64'h0) begin
      n_miss++;
      $display("FAIL reset_rdt: got %h/%h expected 0", bus.ibus_rdt, bus.dbus_rdt);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.mem_cyc, bus.ibus_ack, bus.dbus_ack} !== 3'b0) begin
      n_miss++;
      $display("FAIL idle_after_reset: got %b expected 000", {bus.mem_cyc, bus.ibus_ack, bus.dbus_ack});
    end
  endtask

  task automatic test_ibus_read();
    dev_mem[0][4] = 32'hDEADBEEF;
    ref_mem[0][4] = 32'hDEADBEEF;
    run_single(1'b0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 60, "ibus_read");
  endtask

  task automatic test_dbus_write();
    run_single(1'b1, 1'b1, 32'h0000_0104, 4'b0011, 32'h1234_5678, 4, "dbus_write");
    run_single(1'b0, 1'b0, 32'h0000_0104, 4'hF, 32'h0, 2, "write_readback");
  endtask

  task automatic test_eeprom_reject();
    run_single(1'b1, 1'b1, 32'h0001_0000, 4'hF, 32'hCAFE_F00D, 7, "eeprom_write");
    repeat (5) @(negedge clk);
    n_vec++;
    if (bus.err !== 1'b1) begin
      n_miss++;
      $display("FAIL err_sticky: got %b expected 1", bus.err);
    end
    run_single(1'b0, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 3, "eeprom_ibus_read");
    run_single(1'b1, 1'b0, 32'h0001_0008, 4'hF, 32'h0, 0, "eeprom_dbus_read");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit is_d, we;
      is_d = 1'($urandom);
      we   = is_d & 1'($urandom);
      run_single(is_d, we, $urandom, 4'($urandom_range(1, 15)), $urandom,
                 $urandom_range(0, 8), "random");
    end
  endtask

  task automatic test_drop_cyc();
    int n, log0, pd0;
    bit got;
    logic [31:0] adr, rdt;
    adr = 32'h0000_0A0C;
    log0 = ctl_log.size(); pd0 = ack_d_pulses;
    @(negedge clk);
    ctl_lat = 10;
    bus.dbus_we = 1'b0; bus.dbus_adr = adr; bus.dbus_sel = 4'hF; bus.dbus_cyc = 1'b1;
    repeat (3) @(negedge clk);
    bus.dbus_cyc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.mem_cyc !== 1'b1) begin
      n_miss++;
      $display("FAIL drop_mem_cyc_held: got %b expected 1", bus.mem_cyc);
    end
    n = 5; got = 1'b0; rdt = 'x;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.dbus_ack) begin got = 1'b1; rdt = bus.dbus_rdt; end
    end
    repeat (6) @(negedge clk);
    n_vec++;
    if (!got || n !== 12) begin
      n_miss++;
      $display("FAIL drop_latency: got %0d (acked=%b) expected 12", n, got);
    end
    n_vec++;
    if (rdt !== ref_mem[0][adr[15:2]]) begin
      n_miss++;
      $display("FAIL drop_rdt: got %08h expected %08h", rdt, ref_mem[0][adr[15:2]]);
    end
    n_vec++;
    if ({ack_d_pulses - pd0, ctl_log.size() - log0} !== {32'd1, 32'd1}) begin
      n_miss++;
      $display("FAIL drop_once: got acks=%0d requests=%0d expected 1/1",
               ack_d_pulses - pd0, ctl_log.size() - log0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ctl_lat = 30;
    bus.ibus_adr = 32'h0000_0040; bus.ibus_cyc = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_err = 1'b0;
    n_vec++;
    if ({bus.mem_cyc, bus.ibus_ack, bus.dbus_ack, bus.err} !== 4'b0) begin
      n_miss++;
      $display("FAIL reset_mid: got cyc/iack/dack/err=%b expected 0000",
               {bus.mem_cyc, bus.ibus_ack, bus.dbus_ack, bus.err});
    end
    bus.ibus_cyc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_single(1'b0, 1'b0, 32'h0000_0044, 4'hF, 32'h0, 5, "after_reset_read");
  endtask

  task automatic test_back_to_back();
    logic [31:0] i_adr [4];
    logic [31:0] d_adr [4];
    string got_ord, exp_ord;
    int ii, di, pi0, pd0, lo0, ov0, i_left, d_left;
    grant_t last;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      i_adr[k] = $urandom;
      d_adr[k] = $urandom;
    end
    // Reference order: both always pending while work remains.
    exp_ord = ""; last = GNT_D; i_left = 4; d_left = 4;
    while (i_left + d_left > 0) begin
      if (i_left > 0 && (d_left == 0 || last == GNT_D)) begin
        exp_ord = {exp_ord, "I"}; i_left--; last = GNT_I;
      end else begin
        exp_ord = {exp_ord, "D"}; d_left--; last = GNT_D;
      end
    end
    pi0 = ack_i_pulses; pd0 = ack_d_pulses; lo0 = ack_long; ov0 = ack_overlap;
    @(negedge clk);
    gap_seen = 1'b0; min_gap = 1000;
    ctl_lat = 3;
    bus.ibus_adr = i_adr[0]; bus.ibus_cyc = 1'b1;
    bus.dbus_adr = d_adr[0]; bus.dbus_we = 1'b0; bus.dbus_sel = 4'hF; bus.dbus_cyc = 1'b1;
    got_ord = ""; ii = 0; di = 0;
    for (int t = 0; t < 500 && (ii < 4 || di < 4); t++) begin
      @(negedge clk);
      if (bus.ibus_ack && ii < 4) begin
        got_ord = {got_ord, "I"};
        n_vec++;
        if (bus.ibus_rdt !== ref_mem[i_adr[ii][16]][i_adr[ii][15:2]]) begin
          n_miss++;
          $display("FAIL tie_ibus_rdt[%0d]: got %08h expected %08h", ii, bus.ibus_rdt,
                   ref_mem[i_adr[ii][16]][i_adr[ii][15:2]]);
        end
        ii++;
        if (ii < 4) bus.ibus_adr = i_adr[ii]; else bus.ibus_cyc = 1'b0;
      end
      if (bus.dbus_ack && di < 4) begin
        got_ord = {got_ord, "D"};
        n_vec++;
        if (bus.dbus_rdt !== ref_mem[d_adr[di][16]][d_adr[di][15:2]]) begin
          n_miss++;
          $display("FAIL tie_dbus_rdt[%0d]: got %08h expected %08h", di, bus.dbus_rdt,
                   ref_mem[d_adr[di][16]][d_adr[di][15:2]]);
        end
        di++;
        if (di < 4) bus.dbus_adr = d_adr[di]; else bus.dbus_cyc = 1'b0;
      end
    end
    bus.ibus_cyc = 1'b0; bus.dbus_cyc = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (got_ord != exp_ord) begin
      n_miss++;
      $display("FAIL tie_order: got '%s' expected '%s'", got_ord, exp_ord);
    end
    n_vec++;
    if ({ack_i_pulses - pi0, ack_d_pulses - pd0, ack_long - lo0, ack_overlap - ov0} !==
        {32'd4, 32'd4, 32'd0, 32'd0}) begin
      n_miss++;
      $display("FAIL tie_acks: got i=%0d d=%0d long=%0d overlap=%0d expected 4/4/0/0",
               ack_i_pulses - pi0, ack_d_pulses - pd0, ack_long - lo0, ack_overlap - ov0);
    end
    n_vec++;
    if (min_gap < 2) begin
      n_miss++;
      $display("FAIL tie_cyc_gap: got %0d low cycles expected at least 2", min_gap);
    end
  endtask

  initial begin
    bus.ibus_cyc = 1'b0; bus.ibus_adr = '0;
    bus.dbus_cyc = 1'b0; bus.dbus_we = 1'b0; bus.dbus_adr = '0;
    bus.dbus_sel = '0;   bus.dbus_dat = '0;
    bus.mem_dat_r = '0;  bus.mem_ack = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16384; a++) begin
        dev_mem[d][a] = $urandom;
        ref_mem[d][a] = dev_mem[d][a];
      end

    test_reset();
    test_ibus_read();
    test_dbus_write();
    test_eeprom_reject();
    test_random();
    test_drop_cyc();
    test_reset_mid();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
